// File: rtl/compare_iter_nb_if.sv
// ---------------------------------------------------------------------------
// compare_iter_nb_if
//   Handshake bundle for the iterative magnitude comparator. It carries the
//   operand request channel and the result channel. Each channel uses
//   valid/ready flow control.
//
//   Request channel (master -> slave):
//     in_valid_i   operand pair valid
//     a_i, b_i     operands, N bits each
//     signed_i     1: two's-complement compare, 0: unsigned compare
//     in_ready_o   (slave -> master) comparator can accept operands
//
//   Result channel (slave -> master):
//     out_valid_o  result valid
//     lt_o         a < b
//     eq_o         a == b
//     ge_o         a >= b
//     out_ready_i  (master -> slave) consumer takes the result
//
//   Modports:
//     slave   the comparator side
//     master  the requester/consumer side
// ---------------------------------------------------------------------------
interface compare_iter_nb_if #(
  parameter int N = 32
);

  logic         in_valid_i;
  logic         in_ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         signed_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         lt_o;
  logic         eq_o;
  logic         ge_o;

  modport slave (
    input  in_valid_i,
    input  a_i,
    input  b_i,
    input  signed_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output lt_o,
    output eq_o,
    output ge_o
  );

  modport master (
    output in_valid_i,
    output a_i,
    output b_i,
    output signed_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  lt_o,
    input  eq_o,
    input  ge_o
  );

endinterface

// File: rtl/compare_iter_nb.sv
// ---------------------------------------------------------------------------
// compare_iter_nb
//   Multi-cycle magnitude comparator for the ALU compare path. This path
//   serves BLT/BGE/BLTU/BGEU and SLT/SLTU.
//
//   The block accepts one operand pair. It then walks both operands W bits
//   per cycle, starting with the most significant chunk. It stops at the
//   first chunk that differs and returns lt/eq/ge.
//
//   A signed compare uses the same unsigned datapath. The MSB of both
//   operands is inverted when the pair is captured. This maps the
//   two's-complement order onto the unsigned order.
//
//   Ports:
//     clk_i    clock, rising edge
//     rstn_i   asynchronous active-low reset
//     bus      compare_iter_nb_if.slave. It carries the operand
//              handshake (in_valid_i/in_ready_o, a_i, b_i, signed_i) and
//              the result handshake (out_valid_o/out_ready_i, lt_o, eq_o,
//              ge_o).
//
//   Parameters:
//     N  operand width, N >= 2
//     W  bits examined per cycle, N % W == 0 (W = N gives one compare cycle)
//
//   Timing:
//     accept at cycle 0.
//     out_valid_o rises at cycle k+1, where k (1..N/W) is the number of
//     chunks examined.
//     After the result transfer the block returns to IDLE. It can accept
//     again from the following cycle.
// ---------------------------------------------------------------------------
module compare_iter_nb #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  compare_iter_nb_if.slave bus
);

  // Number of chunks, and the width of the chunk index.
  // The index keeps at least one bit so that W = N still builds.
  localparam int NCHUNK = N / W;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [N-1:0]    a_s;
  logic [N-1:0]    b_s;
  logic [IDXW-1:0] idx_r;
  logic [IDXW-1:0] idx_s;

  logic            out_valid_r;
  logic            out_valid_s;
  logic            lt_r;
  logic            lt_s;
  logic            eq_r;
  logic            eq_s;
  logic            ge_r;
  logic            ge_s;

  logic [W-1:0]    ca_s;
  logic [W-1:0]    cb_s;
  logic            chunk_ne_s;
  logic            chunk_lt_s;
  logic            last_chunk_s;
  logic [N-1:0]    sign_flip_s;

  // This mask inverts the MSB of both operands in signed mode.
  // After the flip, an unsigned compare gives the two's-complement order.
  assign sign_flip_s = {bus.signed_i, {(N-1){1'b0}}};

  // Select the chunk under examination from both captured operands.
  always_comb begin
    ca_s         = a_r[int'(idx_r) * W +: W];
    cb_s         = b_r[int'(idx_r) * W +: W];
    chunk_ne_s   = (ca_s != cb_s);
    chunk_lt_s   = (ca_s < cb_s);
    last_chunk_s = (idx_r == {IDXW{1'b0}});
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  // in_ready_o is exactly (state == IDLE), so in_valid_i alone qualifies
  // the accept condition in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          state_s = ST_CMP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (chunk_ne_s || last_chunk_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CMP;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath logic: next values for operands, index and result flags.
  // All of these are held unless the current state updates them.
  always_comb begin
    a_s         = a_r;
    b_s         = b_r;
    idx_s       = idx_r;
    out_valid_s = out_valid_r;
    lt_s        = lt_r;
    eq_s        = eq_r;
    ge_s        = ge_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          a_s   = bus.a_i ^ sign_flip_s;
          b_s   = bus.b_i ^ sign_flip_s;
          idx_s = IDX_TOP;
        end else begin
          idx_s = idx_r;
        end
      end
      ST_CMP: begin
        if (chunk_ne_s) begin
          // The first differing chunk from the top decides the order.
          lt_s        = chunk_lt_s;
          eq_s        = 1'b0;
          ge_s        = ~chunk_lt_s;
          out_valid_s = 1'b1;
        end else if (last_chunk_s) begin
          lt_s        = 1'b0;
          eq_s        = 1'b1;
          ge_s        = 1'b1;
          out_valid_s = 1'b1;
        end else begin
          idx_s = idx_r - IDXW'(1);
        end
      end
      ST_DONE: begin
        // The flags stay as they are after the transfer. Only valid drops.
        if (bus.out_ready_i) begin
          out_valid_s = 1'b0;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath and result registers.
  // A reset mid-operation discards everything and the chunk index goes back to the top.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_r         <= {N{1'b0}};
      b_r         <= {N{1'b0}};
      idx_r       <= IDX_TOP;
      out_valid_r <= 1'b0;
      lt_r        <= 1'b0;
      eq_r        <= 1'b0;
      ge_r        <= 1'b0;
    end else begin
      a_r         <= a_s;
      b_r         <= b_s;
      idx_r       <= idx_s;
      out_valid_r <= out_valid_s;
      lt_r        <= lt_s;
      eq_r        <= eq_s;
      ge_r        <= ge_s;
    end
  end

  // in_ready_o is decoded from the state register only.
  // It therefore reads 1 while reset holds the state in IDLE.
  assign bus.in_ready_o  = (state_r == ST_IDLE);
  assign bus.out_valid_o = out_valid_r;
  assign bus.lt_o        = lt_r;
  assign bus.eq_o        = eq_r;
  assign bus.ge_o        = ge_r;

endmodule
